// File: rtl/mc_mem_responder.sv
// Memory-side responder for the multicycle CPU: one word access at a time,
// LATENCY wait states, then a one-cycle ready pulse (with err for illegal addresses).
module mc_mem_responder #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        busy
);

  localparam int unsigned Depth   = 2 ** ADDR_W;
  localparam logic [3:0]  CntInit = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q;
  logic [ADDR_W-1:0]   idx_q;
  logic [31:0]         wdata_q;
  logic                illegal_q;
  logic [31:0]         rdata_q;
  logic [31:0]         mem [Depth];

  logic                accept;
  logic                illegal_in;
  logic                acc_en;
  logic                acc_we;
  logic [ADDR_W-1:0]   acc_idx;
  logic [31:0]         acc_wdata;

  assign accept     = (state_q == StIdle) && req;
  // Misaligned, or any byte-address bit above the array span set: no wrap-around.
  assign illegal_in = (addr[1:0] != 2'b00) || ((addr >> (ADDR_W + 2)) != 32'd0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_en    = 1'b0;
    acc_we    = we_q;
    acc_idx   = idx_q;
    acc_wdata = wdata_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (illegal_in) begin
            state_d = StResp;
          end else if (LATENCY == 0) begin
            // Zero wait states: commit straight from the request inputs.
            state_d   = StResp;
            acc_en    = 1'b1;
            acc_we    = we;
            acc_idx   = addr[ADDR_W+1:2];
            acc_wdata = wdata;
          end else begin
            state_d = StWait;
            cnt_d   = CntInit;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
          acc_en  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      we_q      <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= 32'd0;
      illegal_q <= 1'b0;
      rdata_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q      <= we;
        idx_q     <= addr[ADDR_W+1:2];
        wdata_q   <= wdata;
        illegal_q <= illegal_in;
      end
      if (acc_en && !acc_we) begin
        rdata_q <= mem[acc_idx];
      end
    end
  end

  // Storage is not reset; the resetn gate keeps a zero-latency write from
  // landing while reset is held.
  always_ff @(posedge clock) begin
    if (resetn && acc_en && acc_we) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

  assign rdata = rdata_q;
  assign ready = (state_q == StResp);
  assign err   = (state_q == StResp) && illegal_q;
  assign busy  = (state_q != StIdle);

endmodule

// File: tb/tb_mc_mem_responder.sv
// Scoreboard bench for mc_mem_responder: a LATENCY=2 instance and a LATENCY=0
// instance, checked against a small word-array model.
module tb_mc_mem_responder;

  localparam int unsigned AW  = 8;
  localparam int unsigned LAT = 2;

  logic        clock = 1'b0;
  logic        resetn;
  logic        req, we, req0, we0;
  logic [31:0] addr, wdata, addr0, wdata0;
  logic [31:0] rdata, rdata0;
  logic        ready, err, busy, ready0, err0, busy0;

  always #5 clock = ~clock;

  mc_mem_responder #(.ADDR_W(AW), .LATENCY(LAT)) dut (
    .clock (clock), .resetn(resetn), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata (rdata), .ready(ready), .err(err), .busy(busy)
  );

  mc_mem_responder #(.ADDR_W(AW), .LATENCY(0)) dut0 (
    .clock (clock), .resetn(resetn), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .rdata (rdata0), .ready(ready0), .err(err0), .busy(busy0)
  );

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_mem [2][256];
  logic [31:0] model_rd [2];
  int          errors = 0;
  int          checks = 0;

  function automatic logic rdy(input bit z);
    return z ? ready0 : ready;
  endfunction

  function automatic logic erv(input bit z);
    return z ? err0 : err;
  endfunction

  function automatic logic bsy(input bit z);
    return z ? busy0 : busy;
  endfunction

  function automatic logic [31:0] rdv(input bit z);
    return z ? rdata0 : rdata;
  endfunction

  task automatic drive(input bit z, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d);
    if (z) begin
      req0 = r; we0 = w; addr0 = a; wdata0 = d;
    end else begin
      req = r; we = w; addr = a; wdata = d;
    end
  endtask

  // One complete access: push expectation, request for one cycle, wait for ready.
  task automatic access(input bit z, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input string name);
    exp_t e, g;
    logic ill;
    int   n;
    bit   seen;
    ill = (a[1:0] != 2'b00) || ((a >> (AW + 2)) != 32'd0);
    if (!ill) begin
      if (w) model_mem[z][a[AW+1:2]] = d;
      else model_rd[z] = model_mem[z][a[AW+1:2]];
    end
    e.err   = ill;
    e.rdata = model_rd[z];
    e.lat   = ill ? 1 : (z ? 1 : LAT + 1);
    sb.push_back(e);
    @(negedge clock);
    drive(z, 1'b1, w, a, d);
    n    = 0;
    seen = 0;
    while (!seen && n < 40) begin
      @(negedge clock);
      n++;
      if (n == 1) begin
        // Inputs change after acceptance; the captured request must win.
        drive(z, 1'b0, ~w, 32'h0000_0044, ~d);
        checks++;
        if (bsy(z) !== 1'b1) begin
          errors++; $display("FAIL %s busy_after_accept: got %b expected 1", name, bsy(z));
        end
      end
      if (rdy(z) === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL %s ready_timeout: got no ready expected ready", name);
      void'(sb.pop_front());
    end else begin
      g = sb.pop_front();
      if (n != g.lat) begin
        errors++; $display("FAIL %s latency: got %0d expected %0d", name, n, g.lat);
      end
      checks++;
      if (erv(z) !== g.err) begin
        errors++; $display("FAIL %s err: got %b expected %b", name, erv(z), g.err);
      end
      checks++;
      if (rdv(z) !== g.rdata) begin
        errors++; $display("FAIL %s rdata: got %h expected %h", name, rdv(z), g.rdata);
      end
      @(negedge clock);
      checks++;
      if (rdy(z) !== 1'b0 || erv(z) !== 1'b0) begin
        errors++;
        $display("FAIL %s pulse_width: got ready=%b err=%b expected 0 0", name, rdy(z), erv(z));
      end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    model_rd[0] = 32'h0;
    model_rd[1] = 32'h0;
    #12;
    checks++;
    if ({rdata, ready, err, busy} !== 35'h0 || {rdata0, ready0, err0, busy0} !== 35'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h/%b%b%b %h/%b%b%b expected all 0",
               rdata, ready, err, busy, rdata0, ready0, err0, busy0);
    end
    @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic test_basic();
    access(0, 1'b1, 32'h10, 32'hDEAD_BEEF, "t1_write");
    access(0, 1'b0, 32'h10, 32'h0, "t1_read");
  endtask

  task automatic test_illegal();
    access(0, 1'b1, 32'h12, 32'h1234_5678, "t2_misaligned_write");
    access(0, 1'b0, 32'h10, 32'h0, "t2_reread");
    access(0, 1'b0, 32'h400, 32'h0, "t3_read_past_end");
    access(0, 1'b0, 32'h8000_0010, 32'h0, "t3_read_high_bit");
    access(0, 1'b1, 32'h3FC, 32'hA5A5_A5A5, "t3_write_last");
    access(0, 1'b0, 32'h3FC, 32'h0, "t3_read_last");
  endtask

  // req held high: acceptances every period cycles, pulses checked per cycle.
  task automatic test_back_to_back(input bit z, input int period, input int cycles,
                                   input string name);
    exp_t        e, g;
    logic [31:0] a;
    for (int n = 0; n <= cycles; n++) begin
      @(negedge clock);
      checks++;
      if (bsy(z) !== (n % period != 0)) begin
        errors++;
        $display("FAIL %s busy_c%0d: got %b expected %b", name, n, bsy(z), n % period != 0);
      end
      checks++;
      if (rdy(z) !== (n % period == period - 1)) begin
        errors++;
        $display("FAIL %s ready_c%0d: got %b expected %b", name, n, rdy(z),
                 n % period == period - 1);
      end
      if (rdy(z) === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL %s unexpected_ready_c%0d: got ready expected none", name, n);
        end else begin
          g = sb.pop_front();
          if (rdv(z) !== g.rdata || erv(z) !== g.err) begin
            errors++;
            $display("FAIL %s data_c%0d: got %h/%b expected %h/%b", name, n, rdv(z), erv(z),
                     g.rdata, g.err);
          end
        end
      end
      a = ((n / period) % 2 == 1) ? 32'h3FC : 32'h10;
      if (n < cycles) begin
        if (n % period == 0) begin
          model_rd[z] = model_mem[z][a[AW+1:2]];
          e.err   = 1'b0;
          e.rdata = model_rd[z];
          e.lat   = period - 1;
          sb.push_back(e);
        end
        drive(z, 1'b1, 1'b0, a, 32'h0);
      end else begin
        drive(z, 1'b0, 1'b0, 32'h0, 32'h0);
      end
    end
  endtask

  task automatic test_reset_during_wait();
    access(0, 1'b1, 32'h20, 32'h1111_2222, "t5_prewrite");
    @(negedge clock);
    drive(0, 1'b1, 1'b1, 32'h20, 32'hCAFE_F00D);
    @(negedge clock);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL t5_in_wait: got busy=%b expected 1", busy);
    end
    resetn = 1'b0;
    #1;
    model_rd[0] = 32'h0;
    model_rd[1] = 32'h0;
    checks++;
    if ({rdata, ready, err, busy} !== 35'h0) begin
      errors++;
      $display("FAIL t5_async_reset: got %h/%b%b%b expected all 0", rdata, ready, err, busy);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (i == 1) resetn = 1'b1;
      checks++;
      if (ready !== 1'b0) begin
        errors++; $display("FAIL t5_no_ready_c%0d: got %b expected 0", i, ready);
      end
    end
    access(0, 1'b0, 32'h20, 32'h0, "t5_read_old");
  endtask

  task automatic test_zero_latency();
    access(1, 1'b1, 32'h10, 32'h0BAD_F00D, "t6_write");
    access(1, 1'b1, 32'h3FC, 32'h7777_1234, "t6_write_last");
    access(1, 1'b0, 32'h10, 32'h0, "t6_read");
    access(1, 1'b0, 32'h401, 32'h0, "t6_illegal");
    test_back_to_back(1, 2, 10, "t6_throughput");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_illegal();
    test_back_to_back(0, LAT + 2, 20, "t4_held_req");
    test_zero_latency();
    test_reset_during_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
